mem_stage_ctrl: RTL and testbench

- Parametrised successor to the MIPS memory-stage wrapper.
- Converts a pipeline load/store request into a request/response transaction on a variable-latency data-memory port.
- Supports byte, half, word and (for XLEN=64) dword accesses with byte strobes, load sign/zero-extension, misalignment detection and a response timeout.
- Sits between the execute/memory pipeline register and the data memory; holds the pipeline via req_ready while busy.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/mem_lane_align.sv | 64 ++++++
 rtl/mem_stage_ctrl.sv | 144 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the memory-stage controller and its lane aligner.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package mem_pkg;

  // Widest supported bus and address; request structs are sized for these.
  localparam int MAX_XLEN   = 64;
  localparam int MAX_ADDR_W = 64;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } mem_state_t;

  // Latched pipeline request; zext=1 means the load zero-extends.
  typedef struct packed {
    logic                  write;
    mem_size_t             size;
    logic                  zext;
    logic [MAX_ADDR_W-1:0] addr;
    logic [MAX_XLEN-1:0]   wdata;
  } mem_req_t;

  // Number of bytes touched by an access of the given size.
  function automatic int size_bytes(input mem_size_t s);
    return 1 << int'(s);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering: store strobes/replication, load extract/extend, alignment fault.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the outputs are sampled.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFF  = $clog2(NB)
) (
  input  mem_size_t        i_size,
  input  logic             i_zext,
  input  logic [OFF-1:0]   i_lane,
  input  logic [XLEN-1:0]  i_wdata,
  input  logic [XLEN-1:0]  i_rdata,
  output logic [NB-1:0]    o_strb,
  output logic [XLEN-1:0]  o_wdata,
  output logic [XLEN-1:0]  o_rdata,
  output logic             o_misalign
);

  int              w_nb;
  logic [XLEN-1:0] w_shifted;

  assign w_nb      = size_bytes(i_size);
  assign w_shifted = i_rdata >> {i_lane, 3'b000};

  // Strobes and fault: dword is illegal on a 32-bit bus, otherwise the
  // lane offset must be a multiple of the access size.
  always_comb begin
    o_strb     = NB'((1 << w_nb) - 1) << i_lane;
    o_misalign = ((XLEN == 32) && (i_size == DWORD)) ||
                 ((int'(i_lane) & (w_nb - 1)) != 0);
  end

  // Store data: low access-size bytes repeated across every lane.
  always_comb begin
    o_wdata = '0;
    for (int b = 0; b < NB; b++) begin
      o_wdata[8*b +: 8] = i_wdata[8*(b & (w_nb - 1)) +: 8];
    end
  end

  // Load data: shift the addressed lane down, then truncate and extend.
  always_comb begin
    o_rdata = w_shifted;
    case (i_size)
      BYTE: begin
        if (i_zext) o_rdata = XLEN'(w_shifted[7:0]);
        else        o_rdata = XLEN'($signed(w_shifted[7:0]));
      end
      HALF: begin
        if (i_zext) o_rdata = XLEN'(w_shifted[15:0]);
        else        o_rdata = XLEN'($signed(w_shifted[15:0]));
      end
      WORD: begin
        if (i_zext) o_rdata = XLEN'(w_shifted[31:0]);
        else        o_rdata = XLEN'($signed(w_shifted[31:0]));
      end
      default: o_rdata = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// Pipeline load/store to variable-latency data-memory request/response bridge.
// Latency: 4 cycles minimum (accept, REQ, WAIT, RESP); faults answer 1 cycle after accept.
// Backpressure: req_ready only in IDLE; dm_* held stable in REQ until dm_req_ready.
module mem_stage_ctrl
  import mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_misaligned,
  output logic                resp_bus_err,
  output logic                dm_req_valid,
  input  logic                dm_req_ready,
  output logic                dm_we,
  output logic [ADDR_W-1:0]   dm_addr,
  output logic [XLEN/8-1:0]   dm_strb,
  output logic [XLEN-1:0]     dm_wdata,
  input  logic                dm_resp_valid,
  input  logic [XLEN-1:0]     dm_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF   = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  mem_state_t          r_state;
  mem_req_t            r_req;
  logic [ADDR_W-1:0]   r_dm_addr;
  logic [NB-1:0]       r_dm_strb;
  logic [XLEN-1:0]     r_dm_wdata;
  logic                r_dm_we;
  logic [XLEN-1:0]     r_resp_rdata;
  logic                r_misaligned;
  logic                r_bus_err;
  logic [CNT_W-1:0]    r_cnt;

  mem_size_t           w_size;
  logic [OFF-1:0]      w_lane;
  logic [NB-1:0]       w_strb;
  logic [XLEN-1:0]     w_wdata;
  logic [XLEN-1:0]     w_rdata;
  logic                w_misalign;
  logic                w_timeout;
  logic                w_unused_req;

  // The aligner serves the incoming request in IDLE and the latched one later.
  assign w_size = (r_state == IDLE) ? mem_size_t'(req_size) : r_req.size;
  assign w_lane = (r_state == IDLE) ? req_addr[OFF-1:0] : r_req.addr[OFF-1:0];

  // Address pad bits and the raw store data are kept only for visibility.
  assign w_unused_req = ^r_req;

  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .i_size     (w_size),
    .i_zext     (r_req.zext),
    .i_lane     (w_lane),
    .i_wdata    (req_wdata),
    .i_rdata    (dm_rdata),
    .o_strb     (w_strb),
    .o_wdata    (w_wdata),
    .o_rdata    (w_rdata),
    .o_misalign (w_misalign)
  );

  // Transaction FSM plus the request/response registers it owns.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_req        <= '0;
      r_dm_addr    <= '0;
      r_dm_strb    <= '0;
      r_dm_wdata   <= '0;
      r_dm_we      <= 1'b0;
      r_resp_rdata <= '0;
      r_misaligned <= 1'b0;
      r_bus_err    <= 1'b0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_req        <= '{write: req_write,
                              size:  mem_size_t'(req_size),
                              zext:  req_unsigned,
                              addr:  MAX_ADDR_W'(req_addr),
                              wdata: MAX_XLEN'(req_wdata)};
            r_dm_addr    <= {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
            r_dm_strb    <= req_write ? w_strb : '1;
            r_dm_wdata   <= req_write ? w_wdata : '0;
            r_dm_we      <= req_write;
            r_resp_rdata <= '0;
            r_misaligned <= w_misalign;
            r_bus_err    <= 1'b0;
            r_state      <= w_misalign ? RESP : REQ;
          end
        end
        REQ: begin
          if (dm_req_ready) begin
            r_cnt   <= '0;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (dm_resp_valid) begin
            r_resp_rdata <= r_req.write ? '0 : w_rdata;
            r_state      <= RESP;
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready       = (r_state == IDLE);
  assign dm_req_valid    = (r_state == REQ);
  assign resp_valid      = (r_state == RESP);
  assign resp_rdata      = r_resp_rdata;
  assign resp_misaligned = r_misaligned;
  assign resp_bus_err    = r_bus_err;
  assign dm_we           = r_dm_we;
  assign dm_addr         = r_dm_addr;
  assign dm_strb         = r_dm_strb;
  assign dm_wdata        = r_dm_wdata;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl (XLEN=32, TIMEOUT=4).
// Latency: drives one transaction at a time, sampling 1 time unit after each edge.
// Backpressure: stalls dm_req_ready and dm_resp_valid by randomized amounts.
module tb_mem_stage_ctrl;

  localparam int XLEN    = 32;
  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_misaligned;
  logic              resp_bus_err;
  logic              dm_req_valid;
  logic              dm_req_ready;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [XLEN/8-1:0] dm_strb;
  logic [XLEN-1:0]   dm_wdata;
  logic              dm_resp_valid;
  logic [XLEN-1:0]   dm_rdata;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  mem_stage_ctrl #(.XLEN(XLEN), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_unsigned    (req_unsigned),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_bus_err    (resp_bus_err),
    .dm_req_valid    (dm_req_valid),
    .dm_req_ready    (dm_req_ready),
    .dm_we           (dm_we),
    .dm_addr         (dm_addr),
    .dm_strb         (dm_strb),
    .dm_wdata        (dm_wdata),
    .dm_resp_valid   (dm_resp_valid),
    .dm_rdata        (dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every output must sit at its reset value while idle after reset.
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  req_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_mis"},        resp_misaligned, 0);
    chk({tag, "_buserr"},     resp_bus_err, 0);
    chk({tag, "_dm_vld"},     dm_req_valid, 0);
    chk({tag, "_dm_we"},      dm_we, 0);
    chk({tag, "_dm_addr"},    dm_addr, 0);
    chk({tag, "_dm_strb"},    dm_strb, 0);
    chk({tag, "_dm_wdata"},   dm_wdata, 0);
  endtask

  // One complete access; expectations come from the byte-level access rules.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int req_lat,
                         input int resp_lat, input bit tmo);
    int          nb;
    int          lane;
    logic        exp_mis;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd;
    logic [31:0] exp_rd;
    logic [63:0] v;
    logic [63:0] m;

    nb      = 1 << sz;
    lane    = int'(addr % 4);
    exp_mis = (sz == 2'd3) || ((addr % nb) != 0);
    exp_strb = 4'(((1 << nb) - 1) << lane);
    exp_wd  = '0;
    for (int b = 0; b < 4; b++) exp_wd[8*b +: 8] = wd[8*(b % nb) +: 8];
    v = 64'(rd) >> (8 * lane);
    m = (nb >= 8) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    v = v & m;
    if (!uns && v[8*nb-1]) v = v | ~m;
    exp_rd = wr ? 32'd0 : v[31:0];

    chk("idle_ready", req_ready, 1);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    step();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;

    if (exp_mis) begin
      chk("mis_no_dm", dm_req_valid, 0);
      chk("mis_resp_vld", resp_valid, 1);
      chk("mis_flag", resp_misaligned, 1);
      chk("mis_buserr", resp_bus_err, 0);
      chk("mis_rdata", resp_rdata, 0);
    end else begin
      chk("dm_vld", dm_req_valid, 1);
      chk("dm_we", dm_we, wr);
      chk("dm_addr", dm_addr, addr & ~32'd3);
      chk("dm_strb", dm_strb, wr ? exp_strb : 4'hF);
      if (wr) chk("dm_wdata", dm_wdata, exp_wd);
      for (int i = 0; i < req_lat; i++) begin
        dm_req_ready  = 1'b0;
        dm_resp_valid = 1'b1;
        dm_rdata      = $urandom;
        step();
        chk("req_hold_vld", dm_req_valid, 1);
        chk("req_hold_addr", dm_addr, addr & ~32'd3);
        chk("req_no_resp", resp_valid, 0);
      end
      dm_resp_valid = 1'b0;
      dm_req_ready  = 1'b1;
      step();
      dm_req_ready = 1'b0;
      chk("wait_dm_low", dm_req_valid, 0);
      if (tmo) begin
        for (int i = 0; i < TIMEOUT; i++) begin
          chk("tmo_wait", resp_valid, 0);
          step();
        end
        chk("tmo_resp_vld", resp_valid, 1);
        chk("tmo_buserr", resp_bus_err, 1);
        chk("tmo_mis", resp_misaligned, 0);
        chk("tmo_rdata", resp_rdata, 0);
      end else begin
        for (int i = 0; i < resp_lat; i++) begin
          chk("wait_no_resp", resp_valid, 0);
          step();
        end
        dm_resp_valid = 1'b1;
        dm_rdata      = rd;
        step();
        dm_resp_valid = 1'b0;
        dm_rdata      = $urandom;
        chk("resp_vld", resp_valid, 1);
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_mis", resp_misaligned, 0);
        chk("resp_buserr", resp_bus_err, 0);
      end
    end
    step();
    chk("after_resp_vld", resp_valid, 0);
    chk("after_ready", req_ready, 1);
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    resetn        = 1'b0;
    req_valid     = 1'b0;
    req_write     = 1'b0;
    req_size      = 2'd0;
    req_unsigned  = 1'b0;
    req_addr      = '0;
    req_wdata     = '0;
    dm_req_ready  = 1'b0;
    dm_resp_valid = 1'b0;
    dm_rdata      = '0;
    step();
    step();
    chk_reset_outputs("reset");
    resetn = 1'b1;
    step();
    chk_reset_outputs("post_reset");

    // Directed cases: lw minimum latency, lb/lbu sign, sh lanes, misaligned lw, timeout.
    run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 32'h80123456, 0, 0, 1'b0);
    run_txn(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h80123456, 0, 0, 1'b0);
    run_txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 32'h12345678, 0, 0, 1'b0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h101, 32'h0, 32'h0, 0, 0, 1'b0);
    run_txn(1'b0, 2'd3, 1'b0, 32'h108, 32'h0, 32'h0, 0, 0, 1'b0);
    run_txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h0, 1, 0, 1'b1);
    run_txn(1'b0, 2'd1, 1'b0, 32'h006, 32'h0, 32'h8001FFFF, 2, 3, 1'b0);

    // Reset while in WAIT; a late memory response must be ignored.
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h300;
    step();
    req_valid    = 1'b0;
    dm_req_ready = 1'b1;
    step();
    dm_req_ready = 1'b0;
    step();
    resetn = 1'b0;
    step();
    resetn        = 1'b1;
    dm_resp_valid = 1'b1;
    dm_rdata      = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      chk_reset_outputs("rst_wait");
      step();
    end
    dm_resp_valid = 1'b0;

    // Randomized accesses with random stalls and occasional timeouts.
    for (int t = 0; t < 80; t++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
              $urandom_range(0, 2), $urandom_range(0, TIMEOUT - 1),
              ($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
